lsb_mem_port: RTL and testbench

//  Memory-side responder for the LSB request channel: accepts one load/store at a time from the LSB and runs it

---
 rtl/lsb_mem_port_if.sv | 25 ++
 rtl/lsb_mem_port.sv | 196 +++++++++++++++++++
 tb/tb_lsb_mem_port.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsb_mem_port_if.sv
// Request/response channel between the LSB and its memory-side responder.
//   master (LSB side):   drives in_lsb_ready, lsb_op, lsb_instr_type, lsb_addr, lsb_data;
//                        observes welcome_lsb, cache_ready, cache_instr_type, cache_data_out
//   slave (responder):   the reverse
interface lsb_mem_port_if;
   logic        in_lsb_ready;
   logic [2:0]  lsb_op;
   logic [6:0]  lsb_instr_type;
   logic [31:0] lsb_addr;
   logic [31:0] lsb_data;
   logic        welcome_lsb;
   logic        cache_ready;
   logic [6:0]  cache_instr_type;
   logic [31:0] cache_data_out;

   modport master (
      output in_lsb_ready, lsb_op, lsb_instr_type, lsb_addr, lsb_data,
      input  welcome_lsb, cache_ready, cache_instr_type, cache_data_out
   );

   modport slave (
      input  in_lsb_ready, lsb_op, lsb_instr_type, lsb_addr, lsb_data,
      output welcome_lsb, cache_ready, cache_instr_type, cache_data_out
   );
endinterface

// File: rtl/lsb_mem_port.sv
// Memory-side responder for the LSB: takes one load/store at a time and runs
// it byte-serially (little-endian) on the byte-wide RAM/IO port. Load results
// are sign/zero-extended and returned with a one-cycle cache_ready pulse.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; low freezes everything and blocks writes
//   rob_clear       flush: aborts loads, suppresses store completion
//   lsb             request/response channel (slave side)
//   mem_din         read byte, valid one cycle after mem_a
//   mem_dout/mem_a/mem_wr  write byte, byte address, write strobe
//   io_buffer_full  blocks store bytes aimed at the I/O region
//
// state | meaning
// IDLE  | waiting for a request; welcome_lsb may be high
// LOAD  | presenting addresses and collecting read bytes
// STORE | writing bytes, one per cycle unless stalled by I/O
module lsb_mem_port #(
   parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic            rob_clear,
   lsb_mem_port_if.slave   lsb,
   input  logic [7:0]      mem_din,
   output logic [7:0]      mem_dout,
   output logic [31:0]     mem_a,
   output logic            mem_wr,
   input  logic            io_buffer_full
);

   localparam logic [6:0] ST_TYPE = 7'b0100011;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE} state_t;

   state_t          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic [6:0]      type_q, type_d;
   logic [23:0]     data_q, data_d;
   logic [3:0][7:0] buf_q, buf_d;
   logic            clr_q, clr_d;
   logic [31:0]     mem_a_q, mem_a_d;
   logic [7:0]      mem_dout_q, mem_dout_d;
   logic            mem_wr_q, mem_wr_d;
   logic            cache_ready_q, cache_ready_d;
   logic [31:0]     cache_data_q, cache_data_d;
   logic [6:0]      cache_type_q, cache_type_d;

   logic [2:0]      n_bytes;
   logic [2:0]      last_idx;
   logic [1:0]      rx_idx;
   logic            io_stall;
   logic            wr_fire;
   logic            accept;
   logic            sx;
   logic [31:0]     ext;

   assign n_bytes  = (op_q[1:0] == 2'b00) ? 3'd1 :
                     (op_q[1:0] == 2'b01) ? 3'd2 : 3'd4;
   assign last_idx = n_bytes - 3'd1;
   // Read data lags the address by one cycle, so byte cnt-1 arrives now.
   assign rx_idx   = cnt_q[1:0] - 2'd1;
   assign sx       = ~op_q[2];

   assign io_stall = io_buffer_full && (mem_a_q >= IO_BASE);
   // mem_wr_q is only ever set in STORE; the strobe is gated live so that an
   // I/O stall, rdy drop or reset blocks the byte in the same cycle.
   assign wr_fire  = mem_wr_q & rdy & ~rst & ~io_stall;

   assign lsb.welcome_lsb = (state_q == S_IDLE) & rdy & ~rst & ~rob_clear;
   assign accept          = lsb.in_lsb_ready & lsb.welcome_lsb;

   assign mem_a                = mem_a_q;
   assign mem_dout             = mem_dout_q;
   assign mem_wr               = wr_fire;
   assign lsb.cache_ready      = cache_ready_q;
   assign lsb.cache_data_out   = cache_data_q;
   assign lsb.cache_instr_type = cache_type_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      type_d        = type_q;
      data_d        = data_q;
      buf_d         = buf_q;
      clr_d         = clr_q;
      mem_a_d       = mem_a_q;
      mem_dout_d    = mem_dout_q;
      mem_wr_d      = mem_wr_q;
      cache_ready_d = 1'b0;
      cache_data_d  = cache_data_q;
      cache_type_d  = cache_type_q;
      ext           = 32'd0;

      if (rdy) begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_d    = lsb.lsb_op;
                  type_d  = lsb.lsb_instr_type;
                  mem_a_d = lsb.lsb_addr;
                  cnt_d   = 3'd0;
                  clr_d   = 1'b0;
                  if (lsb.lsb_instr_type == ST_TYPE) begin
                     state_d    = S_STORE;
                     mem_wr_d   = 1'b1;
                     mem_dout_d = lsb.lsb_data[7:0];
                     data_d     = lsb.lsb_data[31:8];
                  end else begin
                     state_d  = S_LOAD;
                     mem_wr_d = 1'b0;
                  end
               end
            end

            S_STORE: begin
               // A flushed store is already committed: finish the bytes but
               // do not report completion.
               if (rob_clear) clr_d = 1'b1;
               if (wr_fire) begin
                  if (cnt_q == last_idx) begin
                     state_d       = S_IDLE;
                     mem_wr_d      = 1'b0;
                     cache_ready_d = ~(clr_q | rob_clear);
                     cache_type_d  = type_q;
                     cache_data_d  = 32'd0;
                  end else begin
                     cnt_d      = cnt_q + 3'd1;
                     mem_a_d    = mem_a_q + 32'd1;
                     mem_dout_d = data_q[7:0];
                     data_d     = {8'h00, data_q[23:8]};
                  end
               end
            end

            S_LOAD: begin
               if (rob_clear) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q < last_idx) mem_a_d = mem_a_q + 32'd1;
                  if (cnt_q != 3'd0) buf_d[rx_idx] = mem_din;
                  if (cnt_q == n_bytes) begin
                     case (op_q[1:0])
                        2'b00:   ext = {{24{sx & buf_d[0][7]}}, buf_d[0]};
                        2'b01:   ext = {{16{sx & buf_d[1][7]}}, buf_d[1], buf_d[0]};
                        default: ext = buf_d;
                     endcase
                     state_d       = S_IDLE;
                     cache_ready_d = 1'b1;
                     cache_type_d  = type_q;
                     cache_data_d  = ext;
                  end
               end
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= 3'd0;
         op_q          <= 3'd0;
         type_q        <= 7'd0;
         data_q        <= 24'd0;
         buf_q         <= '0;
         clr_q         <= 1'b0;
         mem_a_q       <= 32'd0;
         mem_dout_q    <= 8'd0;
         mem_wr_q      <= 1'b0;
         cache_ready_q <= 1'b0;
         cache_data_q  <= 32'd0;
         cache_type_q  <= 7'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         op_q          <= op_d;
         type_q        <= type_d;
         data_q        <= data_d;
         buf_q         <= buf_d;
         clr_q         <= clr_d;
         mem_a_q       <= mem_a_d;
         mem_dout_q    <= mem_dout_d;
         mem_wr_q      <= mem_wr_d;
         cache_ready_q <= cache_ready_d;
         cache_data_q  <= cache_data_d;
         cache_type_q  <= cache_type_d;
      end
   end

endmodule

// File: tb/tb_lsb_mem_port.sv
// Directed bench for lsb_mem_port: a byte RAM model that stalls with rdy,
// one task per scenario, each with inline expected-value comparisons.
module tb_lsb_mem_port;
   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;

   logic        clk = 1'b0;
   logic        rst, rdy, rob_clear, io_buffer_full;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  ram [0:4095];
   int          total = 0;
   int          bad = 0;

   lsb_mem_port_if bus();

   lsb_mem_port #(.IO_BASE(32'h0003_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .rob_clear      (rob_clear),
      .lsb            (bus),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .io_buffer_full (io_buffer_full)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rdy) mem_din <= ram[mem_a[11:0]];

   // Inputs change 1 time unit after the rising edge; outputs are sampled
   // on the falling edge.
   task automatic next_cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   // Request is presented for cycle A; returns at the start of cycle A+1.
   task automatic drive_req(input logic [2:0] op, input logic [6:0] ty,
                            input logic [31:0] a, input logic [31:0] d);
      next_cyc();
      bus.in_lsb_ready   = 1'b1;
      bus.lsb_op         = op;
      bus.lsb_instr_type = ty;
      bus.lsb_addr       = a;
      bus.lsb_data       = d;
      next_cyc();
      bus.in_lsb_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
      bus.in_lsb_ready = 1'b0; bus.lsb_op = 3'd0; bus.lsb_instr_type = 7'd0;
      bus.lsb_addr = 32'd0; bus.lsb_data = 32'd0;
      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
      repeat (3) next_cyc();
      mid();
      total++;
      if ({bus.cache_ready, bus.cache_instr_type, bus.cache_data_out, mem_a, mem_dout, mem_wr, bus.welcome_lsb}
          !== {1'b0, 7'd0, 32'd0, 32'd0, 8'd0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_outputs got rdy=%b type=%h data=%h a=%h dout=%h wr=%b wel=%b want all 0",
                  bus.cache_ready, bus.cache_instr_type, bus.cache_data_out, mem_a, mem_dout, mem_wr, bus.welcome_lsb);
      end
      next_cyc();
      rst = 1'b0;
      mid();
      total++;
      if (bus.welcome_lsb !== 1'b1) begin
         bad++; $display("FAIL reset_welcome got %b want 1", bus.welcome_lsb);
      end
   endtask

   task automatic test_store;
      logic [31:0] d = 32'h1234_5678;
      drive_req(3'b010, ST, 32'h100, d);
      for (int k = 0; k < 4; k++) begin
         mid();
         total++;
         if ({mem_wr, mem_a, mem_dout, bus.cache_ready} !== {1'b1, 32'(32'h100 + k), d[8*k +: 8], 1'b0}) begin
            bad++;
            $display("FAIL store_byte%0d got wr=%b a=%h dout=%h crdy=%b want wr=1 a=%h dout=%h crdy=0",
                     k, mem_wr, mem_a, mem_dout, bus.cache_ready, 32'(32'h100 + k), d[8*k +: 8]);
         end
         next_cyc();
      end
      mid();
      total++;
      if ({bus.cache_ready, bus.cache_instr_type, bus.cache_data_out, mem_wr} !== {1'b1, ST, 32'd0, 1'b0}) begin
         bad++;
         $display("FAIL store_done got crdy=%b type=%h data=%h wr=%b want 1 %h 0 0",
                  bus.cache_ready, bus.cache_instr_type, bus.cache_data_out, mem_wr, ST);
      end
      next_cyc();
      mid();
      total++;
      if (bus.cache_ready !== 1'b0) begin
         bad++; $display("FAIL store_pulse_width got %b want 0", bus.cache_ready);
      end
   endtask

   task automatic test_load;
      logic [2:0]  t_op  [0:6];
      logic [31:0] t_adr [0:6];
      logic [31:0] t_exp [0:6];
      int          nb;
      ram[12'h100] = 8'h80;
      ram[12'h101] = 8'h56; ram[12'h102] = 8'h34;
      ram[12'h200] = 8'hFF; ram[12'h201] = 8'h80;
      ram[12'h300] = 8'hEF; ram[12'h301] = 8'hBE; ram[12'h302] = 8'hAD; ram[12'h303] = 8'hDE;
      t_op[0] = 3'b000; t_adr[0] = 32'h100; t_exp[0] = 32'hFFFF_FF80;
      t_op[1] = 3'b100; t_adr[1] = 32'h100; t_exp[1] = 32'h0000_0080;
      t_op[2] = 3'b001; t_adr[2] = 32'h101; t_exp[2] = 32'h0000_3456;
      t_op[3] = 3'b001; t_adr[3] = 32'h200; t_exp[3] = 32'hFFFF_80FF;
      t_op[4] = 3'b101; t_adr[4] = 32'h200; t_exp[4] = 32'h0000_80FF;
      t_op[5] = 3'b010; t_adr[5] = 32'h300; t_exp[5] = 32'hDEAD_BEEF;
      t_op[6] = 3'b000; t_adr[6] = 32'h101; t_exp[6] = 32'h0000_0056;
      for (int v = 0; v < 7; v++) begin
         nb = (t_op[v][1:0] == 2'b00) ? 1 : (t_op[v][1:0] == 2'b01) ? 2 : 4;
         drive_req(t_op[v], LD, t_adr[v], 32'hFFFF_FFFF);
         mid();
         total++;
         if ({mem_a, mem_wr} !== {t_adr[v], 1'b0}) begin
            bad++; $display("FAIL load%0d_addr got a=%h wr=%b want a=%h wr=0", v, mem_a, mem_wr, t_adr[v]);
         end
         for (int c = 2; c <= nb + 1; c++) begin
            next_cyc();
            mid();
         end
         total++;
         if (bus.cache_ready !== 1'b0) begin
            bad++; $display("FAIL load%0d_early got crdy=%b want 0", v, bus.cache_ready);
         end
         next_cyc();
         mid();
         total++;
         if ({bus.cache_ready, bus.cache_instr_type, bus.cache_data_out} !== {1'b1, LD, t_exp[v]}) begin
            bad++;
            $display("FAIL load%0d_result got crdy=%b type=%h data=%h want 1 %h %h",
                     v, bus.cache_ready, bus.cache_instr_type, bus.cache_data_out, LD, t_exp[v]);
         end
      end
   endtask

   task automatic test_back_to_back;
      drive_req(3'b100, LD, 32'h100, 32'd0);
      next_cyc();
      next_cyc();
      bus.in_lsb_ready = 1'b1; bus.lsb_op = 3'b000; bus.lsb_instr_type = ST;
      bus.lsb_addr = 32'h104; bus.lsb_data = 32'h0000_005A;
      mid();
      total++;
      if ({bus.cache_ready, bus.cache_data_out, bus.welcome_lsb} !== {1'b1, 32'h80, 1'b1}) begin
         bad++;
         $display("FAIL b2b_pulse got crdy=%b data=%h wel=%b want 1 00000080 1",
                  bus.cache_ready, bus.cache_data_out, bus.welcome_lsb);
      end
      next_cyc();
      bus.in_lsb_ready = 1'b0;
      mid();
      total++;
      if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h104, 8'h5A}) begin
         bad++; $display("FAIL b2b_write got wr=%b a=%h dout=%h want 1 00000104 5a", mem_wr, mem_a, mem_dout);
      end
      next_cyc();
      mid();
      total++;
      if ({bus.cache_ready, bus.cache_instr_type, bus.cache_data_out} !== {1'b1, ST, 32'd0}) begin
         bad++;
         $display("FAIL b2b_store_done got crdy=%b type=%h data=%h want 1 %h 0",
                  bus.cache_ready, bus.cache_instr_type, bus.cache_data_out, ST);
      end
   endtask

   task automatic test_flush;
      logic seen;
      int   wcount;
      drive_req(3'b010, LD, 32'h300, 32'd0);
      next_cyc();
      rob_clear = 1'b1;
      next_cyc();
      rob_clear = 1'b0;
      mid();
      total++;
      if ({bus.welcome_lsb, mem_a} !== {1'b1, 32'h301}) begin
         bad++; $display("FAIL flush_load_idle got wel=%b a=%h want 1 00000301", bus.welcome_lsb, mem_a);
      end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         seen |= bus.cache_ready;
         next_cyc();
         mid();
      end
      total++;
      if (seen !== 1'b0) begin
         bad++; $display("FAIL flush_load_pulse got %b want 0", seen);
      end

      drive_req(3'b010, ST, 32'h180, 32'hCAFE_F00D);
      wcount = 0;
      seen   = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         rob_clear = (c == 2);
         mid();
         if (c <= 4) wcount += int'(mem_wr);
         else        seen |= bus.cache_ready;
         if (c == 4) begin
            total++;
            if ({mem_a, mem_dout} !== {32'h183, 8'hCA}) begin
               bad++; $display("FAIL flush_store_last got a=%h dout=%h want 00000183 ca", mem_a, mem_dout);
            end
         end
         next_cyc();
      end
      rob_clear = 1'b0;
      total++;
      if (wcount !== 4) begin
         bad++; $display("FAIL flush_store_writes got %0d want 4", wcount);
      end
      total++;
      if (seen !== 1'b0) begin
         bad++; $display("FAIL flush_store_pulse got %b want 0", seen);
      end

      rob_clear = 1'b1;
      bus.in_lsb_ready = 1'b1; bus.lsb_op = 3'b010; bus.lsb_instr_type = LD; bus.lsb_addr = 32'h300;
      mid();
      total++;
      if (bus.welcome_lsb !== 1'b0) begin
         bad++; $display("FAIL flush_idle_welcome got %b want 0", bus.welcome_lsb);
      end
      next_cyc();
      rob_clear = 1'b0;
      bus.in_lsb_ready = 1'b0;
      mid();
      total++;
      if (bus.welcome_lsb !== 1'b1) begin
         bad++; $display("FAIL flush_idle_ignored got wel=%b want 1", bus.welcome_lsb);
      end
   endtask

   task automatic test_io_stall;
      io_buffer_full = 1'b1;
      drive_req(3'b000, ST, 32'h0003_0000, 32'h0000_0041);
      for (int c = 1; c <= 3; c++) begin
         mid();
         total++;
         if (mem_wr !== 1'b0) begin
            bad++; $display("FAIL io_stall_c%0d got wr=%b want 0", c, mem_wr);
         end
         next_cyc();
      end
      io_buffer_full = 1'b0;
      mid();
      total++;
      if ({mem_wr, mem_a, mem_dout, bus.cache_ready} !== {1'b1, 32'h0003_0000, 8'h41, 1'b0}) begin
         bad++;
         $display("FAIL io_write got wr=%b a=%h dout=%h crdy=%b want 1 00030000 41 0", mem_wr, mem_a, mem_dout, bus.cache_ready);
      end
      next_cyc();
      mid();
      total++;
      if ({bus.cache_ready, mem_wr} !== {1'b1, 1'b0}) begin
         bad++; $display("FAIL io_done got crdy=%b wr=%b want 1 0", bus.cache_ready, mem_wr);
      end

      io_buffer_full = 1'b1;
      drive_req(3'b000, ST, 32'h0002_FFFF, 32'h0000_0042);
      mid();
      total++;
      if ({mem_wr, mem_a} !== {1'b1, 32'h0002_FFFF}) begin
         bad++; $display("FAIL io_below_base got wr=%b a=%h want 1 0002ffff", mem_wr, mem_a);
      end
      next_cyc();
      io_buffer_full = 1'b0;
      mid();
   endtask

   task automatic test_rdy_stall;
      drive_req(3'b010, LD, 32'h300, 32'd0);
      next_cyc();
      rdy = 1'b0;
      mid();
      total++;
      if ({bus.welcome_lsb, mem_wr} !== {1'b0, 1'b0}) begin
         bad++; $display("FAIL rdy_low_outputs got wel=%b wr=%b want 0 0", bus.welcome_lsb, mem_wr);
      end
      next_cyc();
      next_cyc();
      next_cyc();
      rdy = 1'b1;
      for (int c = 5; c <= 8; c++) begin
         mid();
         if (c == 8) begin
            total++;
            if (bus.cache_ready !== 1'b0) begin
               bad++; $display("FAIL rdy_load_early got crdy=%b want 0", bus.cache_ready);
            end
         end
         next_cyc();
      end
      mid();
      total++;
      if ({bus.cache_ready, bus.cache_data_out} !== {1'b1, 32'hDEAD_BEEF}) begin
         bad++; $display("FAIL rdy_load_result got crdy=%b data=%h want 1 deadbeef", bus.cache_ready, bus.cache_data_out);
      end

      drive_req(3'b000, ST, 32'h120, 32'h0000_0077);
      rdy = 1'b0;
      mid();
      total++;
      if (mem_wr !== 1'b0) begin
         bad++; $display("FAIL rdy_store_blocked got wr=%b want 0", mem_wr);
      end
      next_cyc();
      rdy = 1'b1;
      mid();
      total++;
      if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h120, 8'h77}) begin
         bad++; $display("FAIL rdy_store_resume got wr=%b a=%h dout=%h want 1 00000120 77", mem_wr, mem_a, mem_dout);
      end
      next_cyc();
      mid();
      total++;
      if (bus.cache_ready !== 1'b1) begin
         bad++; $display("FAIL rdy_store_done got crdy=%b want 1", bus.cache_ready);
      end
   endtask

   task automatic test_reset_mid;
      logic any_wr, any_rdy;
      drive_req(3'b010, ST, 32'h400, 32'hAABB_CCDD);
      next_cyc();
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      mid();
      total++;
      if ({bus.cache_ready, bus.cache_instr_type, bus.cache_data_out, mem_a, mem_dout, mem_wr, bus.welcome_lsb}
          !== {1'b0, 7'd0, 32'd0, 32'd0, 8'd0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL rst_mid_outputs got crdy=%b type=%h data=%h a=%h dout=%h wr=%b wel=%b want 0 0 0 0 0 0 1",
                  bus.cache_ready, bus.cache_instr_type, bus.cache_data_out, mem_a, mem_dout, mem_wr, bus.welcome_lsb);
      end
      any_wr = 1'b0;
      any_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         any_wr  |= mem_wr;
         any_rdy |= bus.cache_ready;
         next_cyc();
         mid();
      end
      total++;
      if ({any_wr, any_rdy} !== 2'b00) begin
         bad++; $display("FAIL rst_mid_quiet got wr=%b crdy=%b want 0 0", any_wr, any_rdy);
      end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_back_to_back();
      test_flush();
      test_io_stall();
      test_rdy_stall();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

endmodule
